seg7_display_driver: RTL and testbench
======================================

Name: seg7_display_driver

Overview:
- Downstream display stage for the calculator.
- Takes the calculator's binary result and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the four active-low digits of the on-board 7-segment display through `an` and `seg`.
- Also exposes a `busy` flag so the calculator core knows when a new result can be loaded.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2.
- DATA_W, 14, width of the binary input value.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- value  input  DATA_W  binary result to display; sampled only on an accepted load.
- load  input  1  single-cycle request to latch `value`.
- busy  output  1  high while a conversion is in progress.
- an  output  4  digit enables, active low; an[0] is the rightmost digit.
- seg  output  8  segments, active low; seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- Reset (rst high at a clk edge):
  - an=4'b1111, seg=8'hFF, busy=0.
  - Displayed digits cleared to 0000.
  - Refresh counter=0, digit index=0.
  - Any conversion in flight is aborted; its result is never shown.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 latches `value` into the shift register, BCD accumulator := 0, busy goes 1 on the next cycle, go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle (add 3 to each nibble ≥5, then shift left 1). Exactly DATA_W cycles, then go to DONE.
  - DONE: copy the four BCD nibbles plus the overflow flag into the display registers in a single cycle (atomic, no partially updated frame). busy goes 0, return to IDLE.
  - Latency: load edge to new digits visible on the display registers = DATA_W+2 cycles (16 at default).
  - load while busy=1 is ignored; no queuing.
  - load and rst asserted together: rst wins.
- Overflow: a latched value >9999 sets the ovf display flag. All four digits then show '-' (only segment g lit, seg=8'hBF).
- Leading-zero blanking:
  - Blank (seg=8'hFF) every digit to the left of the most significant nonzero digit.
  - Digit 0 is always shown, so value 0 displays "   0".
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit index increments 0→1→2→3→0.
  - an is registered, one-hot low for the current index.
  - seg is registered and always in the same cycle as its an.
- First cycle after rst deasserts: an=4'b1110, showing digit 0.
- dp (seg[7]) is always 1 (off).
- Refresh timing is independent of busy; the display never blanks during a conversion.
- value is read only on the cycle a load is accepted.

Optional Feature:
- Macro SEG7_SIGNED_EN.
- When defined:
  - `value` is interpreted as two's complement.
  - Negative values are converted as their magnitude; `-` is shown on the digit immediately left of the most significant nonzero digit.
  - Magnitude >999 when negative, or >9999 when positive, shows overflow "----".
  - Most negative input (-8192) shows overflow.
- When undefined: `value` is unsigned and no minus logic is synthesized.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4.
  - Segment encodings for 0–9.
  - SEG_BLANK=8'hFF, SEG_MINUS=8'hBF.
  - FSM state encodings IDLE/SHIFT/DONE.
  - Overflow threshold 9999.
- Sub-module bin2bcd_seq: the double-dabble FSM.
  - Ports: clk, rst, start, bin, busy, done, bcd[15:0], ovf.
  - Instantiated once. The top level keeps the refresh counter, display registers, blanking and segment decode.

Test Plan (REFRESH_DIV=4 in simulation):
1. rst held 3 cycles then released → an=1111, seg=FF during reset; next cycle an=1110, seg=8'hC0 ('0'); digits 1–3 blank across one full scan.
2. value=1234, load pulse → busy high for 15 cycles. After the next full scan, the an=0111/1011/1101/1110 slots show seg 8'hF9/A4/B0/99 ('1','2','3','4').
3. value=7, load; second load with value=9 during busy → display shows "   7"; the second load is dropped and busy stays a single 15-cycle pulse.
4. value=12000, load → all four digits seg=8'hBF ("----").
5. rst asserted mid-conversion of 5555 → busy=0 next cycle; display shows "   0"; 5555 never appears.
6. With SEG7_SIGNED_EN: value=-42 (14'h3FD6) → digits show " -42" (an=1011 slot seg=8'hBF); value=-1000 → "----".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, segment encodings and converter state type for the 7-segment driver.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS        = 4;
    localparam int unsigned OVF_THRESHOLD     = 9999;
    localparam int unsigned OVF_THRESHOLD_NEG = 999;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // Active-low segments, bit 0 = a ... bit 6 = g, bit 7 = dp (kept off).
    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, DATA_W iterations.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bcd,
    output logic              ovf
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    conv_state_e       state_q;
    logic [DATA_W-1:0] bin_q;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_adj;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 32'(bin) > OVF_THRESHOLD;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[14:0], bin_q[DATA_W-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg7_display_driver.sv
// Binary-to-BCD display stage with 4-digit multiplexed refresh and leading-zero blanking.
// Optional SEG7_SIGNED_EN: two's-complement input with a minus sign left of the leading digit.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DATA_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic [3:0]        an,
    output logic [7:0]        seg
);

    localparam int unsigned RCW = $clog2(REFRESH_DIV);

    logic [RCW-1:0]    refresh_q;
    logic [1:0]        idx_q;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [15:0]       disp_q;
    logic              disp_ovf_q;
    logic [3:0]        lead;
    logic [3:0]        cur;
    logic              conv_busy, conv_done, conv_ovf;
    logic [15:0]       conv_bcd;
    logic [DATA_W-1:0] conv_bin;

`ifdef SEG7_SIGNED_EN
    logic              neg_pend_q, ovf_pend_q, disp_neg_q;
    logic [DATA_W-1:0] mag;

    assign mag      = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
    assign conv_bin = mag;

    // Sign info travels alongside the conversion and is applied with its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (load && !conv_busy) begin
            neg_pend_q <= value[DATA_W-1];
            ovf_pend_q <= value[DATA_W-1] && (32'(mag) > OVF_THRESHOLD_NEG);
        end
    end
`else
    assign conv_bin = value;
`endif

    bin2bcd_seq #(
        .DATA_W(DATA_W)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (rst),
        .start(load),
        .bin  (conv_bin),
        .busy (conv_busy),
        .done (conv_done),
        .bcd  (conv_bcd),
        .ovf  (conv_ovf)
    );

    always_comb begin
        cur     = disp_q[{idx_q, 2'b00} +: 4];
        lead    = '0;
        lead[3] = |disp_q[15:12];
        lead[2] = lead[3] | (|disp_q[11:8]);
        lead[1] = lead[2] | (|disp_q[7:4]);
        lead[0] = lead[1] | (|disp_q[3:0]);
        an_d    = ~(4'b0001 << idx_q);
        seg_d   = SEG_BLANK;
        if (disp_ovf_q) begin
            seg_d = SEG_MINUS;
        end else if (idx_q == 2'd0 || lead[idx_q]) begin
            seg_d = seg_digit(cur);
`ifdef SEG7_SIGNED_EN
        end else if (disp_neg_q && lead[idx_q - 2'd1]) begin
            seg_d = SEG_MINUS;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q  <= '0;
            idx_q      <= '0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_BLANK;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
`ifdef SEG7_SIGNED_EN
            disp_neg_q <= 1'b0;
`endif
        end else begin
            if (refresh_q == RCW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                idx_q     <= idx_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RCW'(1);
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            if (conv_done) begin
                disp_q     <= conv_bcd;
`ifdef SEG7_SIGNED_EN
                disp_ovf_q <= conv_ovf | ovf_pend_q;
                disp_neg_q <= neg_pend_q;
`else
                disp_ovf_q <= conv_ovf;
`endif
            end
        end
    end

    assign busy = conv_busy;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench: loads push values to a queue; a monitor checks busy length and a full scan.
module tb_seg7_display_driver;

    localparam int RD = 4;
    localparam int DW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] value = '0;
    logic          busy;
    logic [3:0]    an;
    logic [7:0]    seg;

    int tests = 0;
    int fails = 0;
    int frames_checked = 0;
    int exp_q[$];
    bit abort_pending = 1'b0;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int directed [16] = '{1234, 12000, 0, 9, 10, 99, 100, 999, 1000, 9999,
                          10000, 16383, 8192, 16342, 15384, 8191};

    always #5 clk = ~clk;

    seg7_display_driver #(
        .REFRESH_DIV(RD),
        .DATA_W     (DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .load (load),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference: expected segment pattern for digit position pos when value v is displayed.
    function automatic logic [7:0] exp_seg(input int v, input int pos);
        int mag, nd, p;
        bit neg;
        mag = v;
        neg = 1'b0;
`ifdef SEG7_SIGNED_EN
        if (v >= (1 << (DW - 1))) begin
            neg = 1'b1;
            mag = (1 << DW) - v;
        end
        if (neg && mag > 999) return 8'hBF;
`endif
        if (mag > 9999) return 8'hBF;
        nd = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (pos < nd) return seg_tbl[(mag / p) % 10];
        if (neg && pos == nd) return 8'hBF;
        return 8'hFF;
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic scan_check(input int v);
        logic [3:0] seen;
        int idx;
        seen = '0;
        for (int k = 0; k < 4 * RD; k++) begin
            @(negedge clk);
            idx = an_index(an);
            if (idx < 0) begin
                check(1'b0, "an_onehot", an, 0);
            end else begin
                seen[idx] = 1'b1;
                check(seg == exp_seg(v, idx), $sformatf("seg_pos%0d_v%0d", idx, v),
                      seg, exp_seg(v, idx));
            end
        end
        check(seen == 4'hF, "scan_cover", seen, 15);
    endtask

    // Monitor: a falling busy marks a presented result.
    initial begin
        int blen;
        int v;
        blen = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                blen++;
            end else if (blen > 0) begin
                if (abort_pending) begin
                    abort_pending = 1'b0;
                    check(blen < DW + 1, "abort_busy_len", blen, DW + 1);
                end else begin
                    check(blen == DW + 1, "busy_len", blen, DW + 1);
                end
                blen = 0;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_result", 0, 0);
                end else begin
                    v = exp_q.pop_front();
                    repeat (3) @(negedge clk);
                    scan_check(v);
                    frames_checked++;
                end
            end
        end
    end

    task automatic issue(input int v);
        @(negedge clk);
        value = DW'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (frames_checked < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        check(frames_checked >= n, "frame_timeout", frames_checked, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        int v;
        int idx;
        nf = 0;

        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check(an == 4'hF && seg == 8'hFF && busy == 1'b0, "reset_state",
                  {busy, an, seg}, 12'hFFF);
        end
        rst = 1'b0;
        @(negedge clk);
        check(an == 4'b1110, "first_an", an, 4'b1110);
        check(seg == 8'hC0, "first_seg", seg, 8'hC0);
        for (int k = 0; k < 4 * RD; k++) begin
            @(negedge clk);
            idx = an_index(an);
            check(idx >= 0 && seg == exp_seg(0, idx), "reset_scan", {an, seg},
                  (idx >= 0) ? exp_seg(0, idx) : 0);
        end

        foreach (directed[i]) begin
            exp_q.push_back(directed[i]);
            issue(directed[i]);
            nf++;
            wait_frames(nf);
        end

        // Second load while busy must be dropped.
        exp_q.push_back(7);
        issue(7);
        repeat (4) @(negedge clk);
        check(busy == 1'b1, "busy_mid", busy, 1);
        value = DW'(9);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        nf++;
        wait_frames(nf);

        // Reset mid-conversion: 5555 must never appear.
        exp_q.push_back(0);
        abort_pending = 1'b1;
        issue(5555);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(busy == 1'b0, "abort_busy", busy, 0);
        rst = 1'b0;
        nf++;
        wait_frames(nf);

        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, (1 << DW) - 1));
            exp_q.push_back(v);
            issue(v);
            nf++;
            wait_frames(nf);
        end

        check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
